fetch_dec_queue: RTL and testbench

- Fetch-side producer of the fetch-to-decode handshake.
- Accepts fetched instruction/PC pairs from the instruction fetch stage and buffers them in a small in-order FIFO.
- Presents the head entry to the decoder on the active-low valid `inst_e_`, with the PC and instruction word alongside.
- Honours the decoder's `dec_stall` back-pressure, raises its own stall toward fetch when full, and discards all contents on a pipeline flush.

---
 rtl/fetch_dec_queue.sv | 150 +++++++++++++++
 tb/tb_fetch_dec_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_dec_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_dec_queue
// Description : Fetch-to-decode instruction queue. Buffers fetched
//               {PC, instruction} pairs in a small in-order FIFO and presents
//               the head entry to the decoder with an active-low valid.
//               Applies back-pressure to fetch when full, honours decoder
//               stall, and discards all contents on a pipeline flush.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR  - PC width in bits
//   INST  - instruction word width in bits
//   DEPTH - number of FIFO entries (power of two, >= 2)
// Ports:
//   clk         in   clock, all state updates on rising edge
//   reset       in   asynchronous active-high reset
//   fetch_e_    in   active-low valid of fetched instruction
//   fetch_pc    in   PC of fetched instruction
//   fetch_inst  in   fetched instruction word
//   fetch_stall out  queue full; fetch must hold its request
//   flush       in   discard all buffered entries
//   dec_stall   in   decoder cannot accept this cycle
//   inst_e_     out  active-low valid of head entry
//   inst_pc     out  head entry PC (0 when empty)
//   inst        out  head entry instruction (0 when empty)
//   occupancy   out  number of valid entries
// ============================================================================
module fetch_dec_queue #(
    parameter int ADDR  = 32,
    parameter int INST  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_e_,
    input  logic [ADDR-1:0]            fetch_pc,
    input  logic [INST-1:0]            fetch_inst,
    output logic                       fetch_stall,
    input  logic                       flush,
    input  logic                       dec_stall,
    output logic                       inst_e_,
    output logic [ADDR-1:0]            inst_pc,
    output logic [INST-1:0]            inst,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] c_CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    // Storage array; contents are don't-care until written, so not reset.
    logic [ADDR-1:0] mem_pc_q   [DEPTH];
    logic [INST-1:0] mem_inst_q [DEPTH];

    logic            w_full;
    logic            w_empty;
    logic            w_enq;
    logic            w_deq;

    // ------------------------------------------------------------------------
    // Status and handshake qualification
    // ------------------------------------------------------------------------
    assign w_full  = (count_q == c_CNT_FULL);
    assign w_empty = (count_q == '0);

    // Enqueue is gated by the registered full flag, so a dequeue in the same
    // cycle does not free a slot for fetch until the following cycle.
    assign w_enq = !fetch_e_ && !w_full && !flush;

    // The decoder stall is meaningless when nothing is presented.
    assign w_deq = !w_empty && !dec_stall && !flush;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            // Flush wins over everything presented this cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_enq) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_deq) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            case ({w_enq, w_deq})
                2'b10:   count_d = count_q + c_CNT_ONE;
                2'b01:   count_d = count_q - c_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq) begin
            mem_pc_q[wr_ptr_q]   <= fetch_pc;
            mem_inst_q[wr_ptr_q] <= fetch_inst;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all derived from registered state, no bypass from fetch_*.
    // The head is forced to zero when empty so stale array contents never
    // leak onto the decoder bus.
    // ------------------------------------------------------------------------
    assign occupancy   = count_q;
    assign fetch_stall = w_full;
    assign inst_e_     = w_empty;
    assign inst_pc     = w_empty ? '0 : mem_pc_q[rd_ptr_q];
    assign inst        = w_empty ? '0 : mem_inst_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_fetch_dec_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_dec_queue
// Description : Self-checking bench for fetch_dec_queue. Directed table of
//               vectors for fill/drain/full/flush, hand sequences for
//               streaming and asynchronous reset, then random traffic
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_dec_queue;

    localparam int ADDR  = 32;
    localparam int INST  = 32;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              fetch_e_;
    logic [ADDR-1:0]   fetch_pc;
    logic [INST-1:0]   fetch_inst;
    logic              fetch_stall;
    logic              flush;
    logic              dec_stall;
    logic              inst_e_;
    logic [ADDR-1:0]   inst_pc;
    logic [INST-1:0]   inst;
    logic [2:0]        occupancy;

    fetch_dec_queue #(
        .ADDR  (ADDR),
        .INST  (INST),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_e_    (fetch_e_),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .dec_stall   (dec_stall),
        .inst_e_     (inst_e_),
        .inst_pc     (inst_pc),
        .inst        (inst),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        bit          fe_n;
        logic [31:0] pc;
        bit          fl;
        bit          ds;
        int          exp_occ;
        bit          exp_e_;
        logic [31:0] exp_pc;
        bit          exp_stall;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    ent_t        mq[$];          // reference queue contents, head at [0]
    logic [31:0] rcv[$];         // PCs the decoder actually consumed

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ":occupancy"},   32'(occupancy),   32'(n));
        chk({tag, ":inst_e_"},     32'(inst_e_),     32'(n == 0));
        chk({tag, ":fetch_stall"}, 32'(fetch_stall), 32'(n == DEPTH));
        chk({tag, ":inst_pc"},     inst_pc,          (n != 0) ? mq[0].pc  : 32'h0);
        chk({tag, ":inst"},        inst,             (n != 0) ? mq[0].ins : 32'h0);
    endtask

    // One clock cycle: drive at posedge+1, record decoder consumption,
    // advance the model, then compare at posedge+1 of the next edge.
    task automatic cycle(input bit fe_n, input logic [31:0] pc, input bit fl,
                         input bit ds, input string tag);
        bit   enq;
        bit   deq;
        ent_t tmp;
        fetch_e_   = fe_n;
        fetch_pc   = pc;
        fetch_inst = mk_inst(pc);
        flush      = fl;
        dec_stall  = ds;
        #1;
        if (!inst_e_ && !ds && !fl) rcv.push_back(inst_pc);
        enq = !fe_n && (mq.size() != DEPTH) && !fl;
        deq = (mq.size() != 0) && !ds && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (deq) tmp = mq.pop_front();
            if (enq) begin
                tmp.pc  = pc;
                tmp.ins = mk_inst(pc);
                mq.push_back(tmp);
            end
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    vec_t vt[19];

    initial begin
        reset      = 1'b1;
        fetch_e_   = 1'b1;
        fetch_pc   = '0;
        fetch_inst = '0;
        flush      = 1'b0;
        dec_stall  = 1'b0;

        // Directed vectors: expected outputs after the edge.
        //           fe_n pc            fl ds occ e_ exp_pc        stall
        vt[0]  = '{0, 32'h100, 0, 1, 1, 0, 32'h100, 0};
        vt[1]  = '{0, 32'h104, 0, 1, 2, 0, 32'h100, 0};
        vt[2]  = '{0, 32'h108, 0, 1, 3, 0, 32'h100, 0};
        vt[3]  = '{0, 32'h10C, 0, 1, 4, 0, 32'h100, 1};
        vt[4]  = '{0, 32'h110, 0, 1, 4, 0, 32'h100, 1};
        vt[5]  = '{1, 32'h000, 0, 0, 3, 0, 32'h104, 0};
        vt[6]  = '{1, 32'h000, 0, 0, 2, 0, 32'h108, 0};
        vt[7]  = '{1, 32'h000, 0, 0, 1, 0, 32'h10C, 0};
        vt[8]  = '{1, 32'h000, 0, 0, 0, 1, 32'h000, 0};
        vt[9]  = '{0, 32'h180, 0, 1, 1, 0, 32'h180, 0};
        vt[10] = '{0, 32'h184, 0, 1, 2, 0, 32'h180, 0};
        vt[11] = '{0, 32'h188, 0, 1, 3, 0, 32'h180, 0};
        vt[12] = '{0, 32'h18C, 0, 1, 4, 0, 32'h180, 1};
        vt[13] = '{0, 32'h200, 0, 0, 3, 0, 32'h184, 0};
        vt[14] = '{0, 32'h200, 0, 1, 4, 0, 32'h184, 1};
        vt[15] = '{1, 32'h000, 0, 0, 3, 0, 32'h188, 0};
        vt[16] = '{0, 32'h300, 1, 0, 0, 1, 32'h000, 0};
        vt[17] = '{0, 32'h400, 0, 1, 1, 0, 32'h400, 0};
        vt[18] = '{1, 32'h000, 0, 0, 0, 1, 32'h000, 0};

        // Reset state, asserted before any clock edge.
        #2;
        chk("rst:occupancy",   32'(occupancy),   32'd0);
        chk("rst:inst_e_",     32'(inst_e_),     32'd1);
        chk("rst:fetch_stall", 32'(fetch_stall), 32'd0);
        chk("rst:inst_pc",     inst_pc,          32'h0);
        chk("rst:inst",        inst,             32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Table-driven fill / drain / full+deq / flush.
        for (int i = 0; i < 19; i++) begin
            cycle(vt[i].fe_n, vt[i].pc, vt[i].fl, vt[i].ds, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d:tbl_occ", i),   32'(occupancy),   32'(vt[i].exp_occ));
            chk($sformatf("vec%0d:tbl_e_", i),    32'(inst_e_),     32'(vt[i].exp_e_));
            chk($sformatf("vec%0d:tbl_pc", i),    inst_pc,          vt[i].exp_pc);
            chk($sformatf("vec%0d:tbl_inst", i),  inst,
                vt[i].exp_e_ ? 32'h0 : mk_inst(vt[i].exp_pc));
            chk($sformatf("vec%0d:tbl_stall", i), 32'(fetch_stall), 32'(vt[i].exp_stall));
        end
        begin
            logic [31:0] exp_rcv[7];
            exp_rcv = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h180, 32'h184, 32'h400};
            chk("tbl:consumed_count", 32'(rcv.size()), 32'd7);
            for (int i = 0; i < 7; i++)
                chk($sformatf("tbl:consumed%0d", i),
                    (i < rcv.size()) ? rcv[i] : 32'hFFFF_FFFF, exp_rcv[i]);
        end
        rcv.delete();

        // Streaming: one push per cycle, decoder always ready.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, $sformatf("stream%0d", i));
            chk($sformatf("stream%0d:occ1", i), 32'(occupancy), 32'd1);
        end
        cycle(1'b1, 32'h0, 1'b0, 1'b0, "stream_tail");
        chk("stream:consumed_count", 32'(rcv.size()), 32'd40);
        for (int i = 0; i < 40; i++)
            chk($sformatf("stream:pc%0d", i),
                (i < rcv.size()) ? rcv[i] : 32'hFFFF_FFFF, 32'h1000 + 32'(4 * i));
        rcv.delete();

        // Asynchronous reset mid-cycle with two entries buffered.
        cycle(1'b0, 32'h600, 1'b0, 1'b1, "ar_push0");
        cycle(1'b0, 32'h604, 1'b0, 1'b1, "ar_push1");
        chk("ar:occ2", 32'(occupancy), 32'd2);
        fetch_e_ = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        mq.delete();
        check_model("ar_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_model("ar_held");
        cycle(1'b0, 32'h700, 1'b0, 1'b1, "ar_resume");
        chk("ar:resume_pc", inst_pc, 32'h700);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, "ar_drain");
        rcv.delete();

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            bit          fe_n;
            bit          fl;
            bit          ds;
            logic [31:0] pc;
            fe_n = ($urandom_range(0, 3) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            ds   = ($urandom_range(0, 1) == 1);
            pc   = $urandom;
            cycle(fe_n, pc, fl, ds, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
